// File: rtl/gnr_pkg.sv
// Shared types and default sizing for the GRN attractor sequencer.
// The state enum is 3 bits so it can be exposed directly on a debug port.
package gnr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STEP  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_NUM_NOS   = 16;
  localparam int DEF_CNT_WIDTH = 32;
  localparam int DEF_MAX_STEPS = 1024;

endpackage

// File: rtl/gnr_attractor_ctrl.sv
// Drives GRN node stages step by step and detects an attractor with Floyd
// tortoise/hare comparison of the nodes' s0 (half speed) and s1 (full speed) copies.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; the producer keeps data stable while valid is high and not yet accepted.
module gnr_attractor_ctrl
  import gnr_pkg::*;
#(
  parameter int NUM_NOS   = DEF_NUM_NOS,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_valid,
  output logic                 init_ready,
  input  logic [NUM_NOS-1:0]   init_data,
  output logic                 reset_nos,
  output logic                 start_s0,
  output logic                 start_s1,
  output logic [NUM_NOS-1:0]   init_state,
  input  logic [NUM_NOS-1:0]   nos_s0,
  input  logic [NUM_NOS-1:0]   nos_s1,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CNT_WIDTH-1:0] result_steps,
  output logic [NUM_NOS-1:0]   result_state,
  output logic                 result_timeout,
  output logic [2:0]           dbg_state
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_STEPS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t r_state;
  state_t w_next;

  logic [CNT_WIDTH-1:0] r_step_cnt;
  logic                 r_init_ready;
  logic                 r_reset_nos;
  logic                 r_start;
  logic                 r_busy;
  logic                 r_result_valid;
  logic                 r_result_timeout;
  logic [NUM_NOS-1:0]   r_init_state;
  logic [CNT_WIDTH-1:0] r_result_steps;
  logic [NUM_NOS-1:0]   r_result_state;

  logic [CNT_WIDTH-1:0] w_step_cnt;
  logic                 w_init_ready;
  logic                 w_reset_nos;
  logic                 w_start;
  logic                 w_busy;
  logic                 w_result_valid;
  logic                 w_result_timeout;
  logic [NUM_NOS-1:0]   w_init_state;
  logic [CNT_WIDTH-1:0] w_result_steps;
  logic [NUM_NOS-1:0]   w_result_state;

  logic w_init_hs;
  logic w_match;
  logic w_limit;

  // init_ready is registered, so it doubles as the IDLE-and-out-of-reset qualifier.
  assign w_init_hs = init_valid & r_init_ready;
  // Odd step counts are skipped: s0 and s1 coincide trivially after step 1.
  assign w_match   = ~r_step_cnt[0] & (nos_s0 == nos_s1);
  assign w_limit   = (r_step_cnt == MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_init_hs) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_STEP;
      ST_STEP:  w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_match || w_limit) w_next = ST_DONE;
        else                    w_next = ST_STEP;
      end
      ST_DONE:  if (result_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each strobe lines up with its state.
  always_comb begin
    w_init_ready     = (w_next == ST_IDLE);
    w_reset_nos      = (w_next == ST_LOAD);
    w_start          = (w_next == ST_STEP);
    w_busy           = (w_next != ST_IDLE);
    w_result_valid   = (w_next == ST_DONE);
    w_step_cnt       = r_step_cnt;
    w_init_state     = r_init_state;
    w_result_steps   = r_result_steps;
    w_result_state   = r_result_state;
    w_result_timeout = r_result_timeout;

    if (r_state == ST_IDLE && w_init_hs) begin
      w_init_state = init_data;
      w_step_cnt   = '0;
    end
    // The counter can only reach STEP again below the limit, so it never wraps.
    if (w_next == ST_STEP) begin
      w_step_cnt = r_step_cnt + CNT_ONE;
    end
    if (r_state == ST_CHECK && w_next == ST_DONE) begin
      w_result_steps   = r_step_cnt;
      w_result_state   = nos_s1;
      w_result_timeout = ~w_match;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt       <= '0;
      r_init_ready     <= 1'b0;
      r_reset_nos      <= 1'b0;
      r_start          <= 1'b0;
      r_busy           <= 1'b0;
      r_result_valid   <= 1'b0;
      r_result_timeout <= 1'b0;
      r_init_state     <= '0;
      r_result_steps   <= '0;
      r_result_state   <= '0;
    end else begin
      r_step_cnt       <= w_step_cnt;
      r_init_ready     <= w_init_ready;
      r_reset_nos      <= w_reset_nos;
      r_start          <= w_start;
      r_busy           <= w_busy;
      r_result_valid   <= w_result_valid;
      r_result_timeout <= w_result_timeout;
      r_init_state     <= w_init_state;
      r_result_steps   <= w_result_steps;
      r_result_state   <= w_result_state;
    end
  end

  assign init_ready     = r_init_ready;
  assign reset_nos      = r_reset_nos;
  assign start_s0       = r_start;
  assign start_s1       = r_start;
  assign busy           = r_busy;
  assign result_valid   = r_result_valid;
  assign result_timeout = r_result_timeout;
  assign init_state     = r_init_state;
  assign result_steps   = r_result_steps;
  assign result_state   = r_result_state;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: two instances (long and short step limit) run
// side by side on a bench-modelled 4-node network.
module tb_gnr_attractor_ctrl;

  localparam int N     = 4;
  localparam int CW    = 32;
  localparam int MAX_A = 1024;
  localparam int MAX_B = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         init_valid = 1'b0;
  logic [N-1:0] init_data  = '0;

  logic          init_ready[2];
  logic          reset_nos[2];
  logic          start_s0[2];
  logic          start_s1[2];
  logic          busy[2];
  logic          result_valid[2];
  logic          result_ready[2];
  logic          result_timeout[2];
  logic [N-1:0]  init_state[2];
  logic [N-1:0]  nos_s0[2];
  logic [N-1:0]  nos_s1[2];
  logic [N-1:0]  result_state[2];
  logic [CW-1:0] result_steps[2];
  logic [2:0]    dbg_state[2];

  int checks = 0;
  int errors = 0;

  int           net_sel = 0;
  logic [N-1:0] lut[16];

  function automatic logic [N-1:0] f_net(input logic [N-1:0] x);
    case (net_sel)
      0:       return x;
      1:       return {x[2:0], x[3]};
      default: return lut[x];
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [N-1:0] s0_r;
    logic [N-1:0] s1_r;
    logic         pass_r;

    gnr_attractor_ctrl #(
      .NUM_NOS  (N),
      .CNT_WIDTH(CW),
      .MAX_STEPS(g == 0 ? MAX_A : MAX_B)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .init_valid    (init_valid),
      .init_ready    (init_ready[g]),
      .init_data     (init_data),
      .reset_nos     (reset_nos[g]),
      .start_s0      (start_s0[g]),
      .start_s1      (start_s1[g]),
      .init_state    (init_state[g]),
      .nos_s0        (nos_s0[g]),
      .nos_s1        (nos_s1[g]),
      .busy          (busy[g]),
      .result_valid  (result_valid[g]),
      .result_ready  (result_ready[g]),
      .result_steps  (result_steps[g]),
      .result_state  (result_state[g]),
      .result_timeout(result_timeout[g]),
      .dbg_state     (dbg_state[g])
    );

    // Node array: s0 moves on every other start (pass flag), s1 on every start.
    always_ff @(posedge clk) begin
      if (rst) begin
        s0_r <= '0; s1_r <= '0; pass_r <= 1'b0;
      end else if (reset_nos[g]) begin
        s0_r <= init_state[g]; s1_r <= init_state[g]; pass_r <= 1'b1;
      end else begin
        if (start_s0[g]) begin
          if (pass_r) s0_r <= f_net(s0_r);
          pass_r <= ~pass_r;
        end
        if (start_s1[g]) s1_r <= f_net(s1_r);
      end
    end
    assign nos_s0[g] = s0_r;
    assign nos_s1[g] = s1_r;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the trajectory x_k = f^k(x) and stop at the first even k
  // with x_{k/2} == x_k, or at the step limit.
  task automatic ref_run(input logic [N-1:0] x, input int maxs,
                         output int steps, output logic [N-1:0] st, output logic to);
    logic [N-1:0] seq[0:MAX_A];
    seq[0] = x;
    steps  = maxs;
    to     = 1'b1;
    for (int k = 1; k <= maxs; k++) begin
      seq[k] = f_net(seq[k-1]);
      if (k % 2 == 0 && seq[k/2] == seq[k]) begin
        steps = k; st = seq[k]; to = 1'b0;
        return;
      end
    end
    st = seq[maxs];
  endtask

  // Starts at a negedge; returns at the negedge after the handshake edge.
  task automatic handshake(input logic [N-1:0] x);
    int w = 0;
    while (!(init_ready[0] && init_ready[1]) && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("init_ready_idle", {62'b0, init_ready[1], init_ready[0]}, 64'h3);
    init_valid = 1'b1;
    init_data  = x;
    @(negedge clk);
    init_valid = 1'b0;
  endtask

  task automatic run(input logic [N-1:0] x, input int rd_delay, input bit pulse,
                     input int es0, input int es1,
                     input logic [N-1:0] ss0, input logic [N-1:0] ss1,
                     input logic to0, input logic to1);
    int           es[2];
    logic [N-1:0] ss[2];
    logic         eto[2];
    int           starts[2], loads[2], lat[2], hold[2];
    bit           done[2], acked[2];
    logic [CW-1:0] cap_steps[2];
    logic [N-1:0]  cap_state[2];
    logic          cap_to[2];
    int e;
    es[0] = es0;  es[1] = es1;
    ss[0] = ss0;  ss[1] = ss1;
    eto[0] = to0; eto[1] = to1;
    for (int g = 0; g < 2; g++) begin
      starts[g] = 0; loads[g] = 0; lat[g] = 0; hold[g] = 0;
      done[g] = 1'b0; acked[g] = 1'b0;
    end
    handshake(x);
    e = 0;
    while (!(done[0] && done[1]) && e < 2 * MAX_A + 40) begin
      e++;
      if (pulse && e == 3) begin init_valid = 1'b1; init_data = ~x; end
      if (pulse && e == 4) begin init_valid = 1'b0; init_data = x; end
      for (int g = 0; g < 2; g++) begin
        if (done[g]) continue;
        if (acked[g]) begin
          chk($sformatf("valid_drop_%0d", g), result_valid[g], 1'b0);
          chk($sformatf("back_idle_ready_%0d", g), init_ready[g], 1'b1);
          chk($sformatf("back_idle_busy_%0d", g), busy[g], 1'b0);
          result_ready[g] = 1'b0;
          done[g] = 1'b1;
          continue;
        end
        if (pulse && e == 5) chk($sformatf("init_state_hold_%0d", g), init_state[g], x);
        if (reset_nos[g]) begin
          loads[g]++;
          chk($sformatf("reset_nos_cycle_%0d", g), e, 1);
        end
        if (start_s0[g] || start_s1[g]) begin
          starts[g]++;
          chk($sformatf("start_pair_%0d", g), {start_s0[g], start_s1[g]}, 2'b11);
        end
        if (result_valid[g]) begin
          if (lat[g] == 0) begin
            lat[g] = e;
            cap_steps[g] = result_steps[g];
            cap_state[g] = result_state[g];
            cap_to[g]    = result_timeout[g];
            chk($sformatf("latency_%0d", g), e, 2 + 2 * es[g]);
            chk($sformatf("steps_%0d", g), result_steps[g], es[g]);
            chk($sformatf("state_%0d", g), result_state[g], ss[g]);
            chk($sformatf("timeout_%0d", g), result_timeout[g], eto[g]);
            chk($sformatf("start_count_%0d", g), starts[g], es[g]);
            chk($sformatf("load_count_%0d", g), loads[g], 1);
          end else begin
            chk($sformatf("hold_steps_%0d", g), result_steps[g], cap_steps[g]);
            chk($sformatf("hold_state_%0d", g), result_state[g], cap_state[g]);
            chk($sformatf("hold_timeout_%0d", g), result_timeout[g], cap_to[g]);
          end
          chk($sformatf("done_init_ready_%0d", g), init_ready[g], 1'b0);
          hold[g]++;
          if (hold[g] > rd_delay) begin
            result_ready[g] = 1'b1;
            acked[g] = 1'b1;
          end
        end else begin
          chk($sformatf("busy_run_%0d", g), busy[g], 1'b1);
        end
      end
      @(negedge clk);
    end
    chk("run_completed", {62'b0, done[1], done[0]}, 64'h3);
    init_valid = 1'b0;
    result_ready[0] = 1'b0;
    result_ready[1] = 1'b0;
  endtask

  typedef struct {
    int           net;
    logic [N-1:0] init;
    int           rd_delay;
    bit           pulse;
    int           steps_a;
    int           steps_b;
    logic [N-1:0] state_a;
    logic [N-1:0] state_b;
    logic         to_a;
    logic         to_b;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int           ea, eb;
    logic [N-1:0] sa, sb;
    logic         ta, tb;
    logic [N-1:0] x;

    vecs[0] = '{0, 4'b1010, 0, 1'b0, 2, 2, 4'b1010, 4'b1010, 1'b0, 1'b0};
    vecs[1] = '{1, 4'b0001, 0, 1'b0, 8, 6, 4'b0001, 4'b0100, 1'b0, 1'b1};
    vecs[2] = '{0, 4'b0110, 5, 1'b0, 2, 2, 4'b0110, 4'b0110, 1'b0, 1'b0};
    vecs[3] = '{1, 4'b0001, 1, 1'b1, 8, 6, 4'b0001, 4'b0100, 1'b0, 1'b1};
    result_ready[0] = 1'b0;
    result_ready[1] = 1'b0;
    for (int i = 0; i < 16; i++) lut[i] = N'(i);

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_init_ready_%0d", g), init_ready[g], 1'b0);
      chk($sformatf("rst_busy_%0d", g), busy[g], 1'b0);
      chk($sformatf("rst_valid_%0d", g), result_valid[g], 1'b0);
      chk($sformatf("rst_strobes_%0d", g), {reset_nos[g], start_s0[g], start_s1[g]}, 3'b000);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle_init_ready", {62'b0, init_ready[1], init_ready[0]}, 64'h3);

    foreach (vecs[i]) begin
      net_sel = vecs[i].net;
      run(vecs[i].init, vecs[i].rd_delay, vecs[i].pulse,
          vecs[i].steps_a, vecs[i].steps_b, vecs[i].state_a, vecs[i].state_b,
          vecs[i].to_a, vecs[i].to_b);
    end

    // Reset in the CHECK cycle after step 3, then a clean rerun.
    net_sel = 1;
    handshake(4'b0001);
    repeat (6) @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk($sformatf("pre_rst_check_state_%0d", g), dbg_state[g], 3'd3);
    rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("mid_rst_state_%0d", g), dbg_state[g], 3'd0);
      chk($sformatf("mid_rst_flags_%0d", g),
          {init_ready[g], reset_nos[g], start_s0[g], start_s1[g], busy[g],
           result_valid[g], result_timeout[g]}, 7'b0);
      chk($sformatf("mid_rst_data_%0d", g),
          {init_state[g], result_steps[g], result_state[g]}, '0);
    end
    rst = 1'b0;
    @(negedge clk);
    run(4'b0001, 0, 1'b0, 8, 6, 4'b0001, 4'b0100, 1'b0, 1'b1);

    // Random functional networks checked against the trajectory model.
    net_sel = 2;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) lut[i] = N'($urandom_range(0, 15));
      x = N'($urandom_range(0, 15));
      ref_run(x, MAX_A, ea, sa, ta);
      ref_run(x, MAX_B, eb, sb, tb);
      run(x, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ea, eb, sa, sb, ta, tb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gnr_attractor_ctrl.md
Name: gnr_attractor_ctrl

Overview:
- Sequencer that drives all GRN node stages (node enable/reset inputs) and consumes their dual state outputs to detect an attractor with tortoise/hare (Floyd) cycle detection.
- Each node's s0 copy advances every other step (tortoise); its s1 copy advances every step (hare).
- The block loads an initial network state, issues steps, and compares the s0 vector against the s1 vector. It reports the step count at first match, or a timeout, through a valid/ready result port.

Parameters:
- NUM_NOS, 16, number of network nodes (width of state vectors)
- CNT_WIDTH, 32, width of step counter and result count
- MAX_STEPS, 1024, step limit before timeout; must be even, >=2, < 2**CNT_WIDTH

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- init_valid  input  1  initial state offered
- init_ready  output  1  high in IDLE only; transfer when init_valid & init_ready
- init_data  input  NUM_NOS  initial state, bit i -> node i
- reset_nos  output  1  broadcast to all nodes; loads init_state into s0/s1 and sets node pass flag
- start_s0  output  1  broadcast step enable, tortoise copy
- start_s1  output  1  broadcast step enable, hare copy
- init_state  output  NUM_NOS  per-node init value, bit i -> node i
- nos_s0  input  NUM_NOS  concatenated node s0 outputs
- nos_s1  input  NUM_NOS  concatenated node s1 outputs
- busy  output  1  high in any state except IDLE
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result
- result_steps  output  CNT_WIDTH  step count at match or timeout
- result_state  output  NUM_NOS  nos_s1 captured at decision
- result_timeout  output  1  1 = MAX_STEPS reached without match

Behaviour:
- All outputs are registered.
- Reset values: init_ready=0 during rst, then 1 in IDLE. reset_nos, start_s0, start_s1, busy, result_valid, result_timeout = 0. init_state, result_steps, result_state = 0. step_cnt=0. State=IDLE.
- FSM states: IDLE, LOAD, STEP, CHECK, DONE.
- IDLE:
  - init_ready=1.
  - On handshake: latch init_data into init_state, assert reset_nos for exactly 1 cycle (LOAD), clear step_cnt, go to LOAD.
- LOAD:
  - reset_nos=1 for this cycle.
  - Go to STEP.
- STEP:
  - start_s0=start_s1=1 for exactly 1 cycle.
  - step_cnt += 1.
  - Go to CHECK.
- CHECK:
  - Node registers hold the post-step value; start_* = 0.
  - After k steps, node s0 = f^ceil(k/2)(x) and s1 = f^k(x).
  - Match is evaluated only when step_cnt is even: match = (nos_s0 == nos_s1).
  - Match has priority over timeout. If match: result_timeout=0, go to DONE.
  - Else if step_cnt == MAX_STEPS: result_timeout=1, go to DONE.
  - Else go to STEP.
  - On DONE entry, capture result_steps=step_cnt and result_state=nos_s1.
- DONE:
  - result_valid=1; result fields stable until result_ready sampled high.
  - On handshake: result_valid=0 next cycle, go to IDLE.
- Cadence: one step per 2 cycles. Latency from init handshake to result_valid = 2 + 2*k cycles.
- Odd step_cnt: never a match, even when vectors are equal. Step 1 is always trivially equal.
- init_valid outside IDLE is ignored; init_ready=0.
- rst in any state returns to IDLE next cycle with reset values. Nodes see reset_nos=0, start_*=0; nodes have their own rst.
- step_cnt never exceeds MAX_STEPS; no wrap.

Decomposition:
- Shared package gnr_pkg: FSM state enum (3-bit encoding); localparams for default NUM_NOS, CNT_WIDTH, MAX_STEPS.
- No sub-module needed. The equality compare and counter are inline; the bench supplies the node array.

Test Plan:
- Identity network (f(x)=x), NUM_NOS=4, init_data=4'b1010 -> reset_nos one pulse, then result after step 2: result_steps=2, result_state=4'b1010, result_timeout=0, result_valid 6 cycles after handshake.
- Rotate-left-by-1 network, init 4'b0001 (period 4) -> first even k with f^(k/2)=f^k is k=8: result_steps=8, result_state=4'b0001, timeout=0.
- Rotate network, MAX_STEPS=6 -> result_timeout=1, result_steps=6, result_state=4'b0100; start_* asserted exactly 6 times.
- Backpressure: result_ready low for 5 cycles in DONE -> result_valid and all result fields constant; init_ready=0; one cycle after result_ready=1, back in IDLE with init_ready=1.
- rst asserted in CHECK after step 3 -> next cycle: IDLE, all outputs at reset values. A new init then yields an identical result to a clean run.
- init_valid pulsed while busy -> not accepted, init_state unchanged, run result unaffected.
